decoder_stream_onehot: RTL and testbench
========================================

Name: decoder_stream_onehot

Overview:
- Streaming binary-to-one-hot decoder: the receiving end for codes produced by the team's N-to-log2 encoders.
- Accepts N-bit codes over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives each decoded one-hot word on out_onehot for HOLD cycles, then issues the next word back-to-back or returns to idle.
- Sits between the encoder-side code source and one-hot consumers (select lines, enables).

Parameters:
N, 2, input code width; one-hot output width M = 2**N
HOLD, 1, cycles each one-hot word stays asserted; legal range 1..255, HOLD=0 illegal
CNT_W, 8, width of the decoded-word counter

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  source presents in_code
in_ready  output  1  decoder can accept a code (FIFO not full)
in_code  input  N  binary code to decode
en  input  1  allows popping the next code from the FIFO; does not abort a word in progress
out_valid  output  1  out_onehot holds a decoded word
out_onehot  output  M  one-hot word, bit in_code set
busy  output  1  state DRIVE or FIFO non-empty
count  output  CNT_W  number of words driven to the output, modulo 2**CNT_W

Behaviour:
- Reset (async, rst=1), effective immediately:
  - out_onehot=0, out_valid=0, count=0, FIFO empty, state IDLE, hold counter 0.
  - in_ready=1 and busy=0 while in reset and after release.
- Handshake:
  - Push occurs at a rising edge when in_valid && in_ready.
  - in_ready = !fifo_full, decoded from registered state only; no combinational path from in_valid or pop.
  - in_code is sampled only on a push.
  - in_valid with in_ready=0 has no effect; the source holds its data.
- FIFO: 2 entries, in-order.
  - Push and pop in the same cycle are allowed when the FIFO is non-empty and not full.
  - When full, a same-cycle pop frees a slot; in_ready rises the following cycle.
- FSM state IDLE: if FIFO non-empty && en, at the edge:
  - pop the head code c;
  - out_onehot = 1<<c, out_valid=1, hold=HOLD-1, count+=1;
  - go to DRIVE.
  - Otherwise remain in IDLE with outputs 0.
- FSM state DRIVE:
  - hold!=0: hold-=1; outputs unchanged.
  - hold==0 and FIFO non-empty and en: pop the next code, load a new word as in IDLE, stay in DRIVE. Output changes without a gap cycle.
  - hold==0 otherwise: out_onehot=0, out_valid=0, go to IDLE.
- Latency:
  - A code pushed at edge k into an empty FIFO, with state IDLE and en=1, appears on out_onehot after edge k+1.
  - A push at edge k is not visible to the pop logic until edge k+1; there is no bypass.
- Each word is asserted for exactly HOLD consecutive cycles.
- Throughput: one word per HOLD cycles when the FIFO stays non-empty.
- en:
  - Sampled only at load decisions.
  - en=0 during DRIVE lets the current word finish, then the FSM goes to IDLE and the FIFO contents are retained.
- Width rules:
  - out_onehot has exactly one bit set when out_valid=1, else all zero.
  - count wraps from 2**CNT_W-1 to 0.
- Reset mid-operation: all state cleared and buffered codes discarded; no partial word appears after release.

Test Plan:
- Reset then idle, N=2, HOLD=1: assert rst mid-cycle -> out_onehot=0000, out_valid=0, in_ready=1, count=0 asynchronously; after release, idle with no stimulus -> outputs stay 0.
- Single code, N=2, HOLD=1: push code 2 at edge 1 -> out_onehot=0100 and out_valid=1 after edge 2 only; 0000 after edge 3; count=1.
- Back-to-back stream, N=2, HOLD=3: push 0,1,3,2 as fast as in_ready allows:
  - outputs 0001, 0010, 1000, 0100, each held for exactly 3 cycles with no gaps;
  - in_ready drops to 0 while the FIFO holds 2 entries;
  - count=4.
- Flow control, HOLD=1, en=0: push 1 and 3 -> in_ready=0 after the second push, no output. Raise en -> 0010 then 1000 on consecutive cycles. in_ready returns to 1 one cycle after the first pop.
- en drop mid-word, HOLD=4: drop en at cycle 2 of word 0001 with code 3 queued -> 0001 completes its 4 cycles, then outputs go 0000 and the FSM returns to IDLE. Raising en later -> 1000 one cycle after.
- Reset during DRIVE plus count wrap:
  - rst mid-word with a full FIFO -> outputs clear at once and nothing is emitted after release;
  - separately, 256 words with CNT_W=8 -> count reads 0.

Source files
------------

// File: rtl/decoder_stream_onehot.sv
// Streaming binary-to-one-hot decoder: a 2-entry code FIFO feeds an output FSM that holds each word HOLD cycles.
// A code pushed into an empty FIFO is on out_onehot one edge later; in_ready is low only while the FIFO is full.
module decoder_stream_onehot #(
  parameter int N     = 2,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  input  logic              en,
  output logic              out_valid,
  output logic [2**N-1:0]   out_onehot,
  output logic              busy,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic {S_IDLE, S_DRIVE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [N-1:0]     r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_fill;
  logic [7:0]       r_hold;
  logic [N-1:0]     r_code;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_load;

  assign w_empty = (r_fill == 2'd0);
  assign w_full  = (r_fill == 2'd2);
  assign w_push  = in_valid && !w_full;
  // A load happens from IDLE or on the last cycle of the current word; it is also the FIFO pop.
  assign w_load  = !w_empty && en && ((r_state == S_IDLE) || (r_hold == 8'd0));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_load) begin
        r_rptr <= ~r_rptr;
      end
      r_fill <= r_fill + {1'b0, w_push} - {1'b0, w_load};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load) begin
          w_next = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if ((r_hold == 8'd0) && !w_load) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold  <= 8'd0;
      r_code  <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_hold  <= 8'(HOLD - 1);
      r_code  <= r_mem[r_rptr];
      r_count <= r_count + 1'b1;
    end else if ((r_state == S_DRIVE) && (r_hold != 8'd0)) begin
      r_hold <= r_hold - 8'd1;
    end
  end

  always_comb begin
    out_valid  = (r_state == S_DRIVE);
    out_onehot = '0;
    if (r_state == S_DRIVE) begin
      out_onehot[r_code] = 1'b1;
    end
  end

  assign in_ready = !w_full;
  assign busy     = (r_state == S_DRIVE) || !w_empty;
  assign count    = r_count;

endmodule

// File: tb/tb_decoder_stream_onehot.sv
// Bench for decoder_stream_onehot: three instances (HOLD=1,3,4) share stimulus; each is tracked by a
// queue-and-remaining-cycles model of the stream behaviour.
module tb_decoder_stream_onehot;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             en;
  logic [1:0]       in_code;
  logic [2:0]       o_rdy;
  logic [2:0]       o_vld;
  logic [2:0]       o_busy;
  logic [2:0][3:0]  o_oh;
  logic [2:0][7:0]  o_cnt;

  int checks   = 0;
  int failures = 0;

  int         hold_v [3] = '{1, 3, 4};
  int         m_n    [3];
  int         m_left [3];
  int         m_word [3];
  int         m_words[3];
  logic [1:0] m_fifo [3][2];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      decoder_stream_onehot #(
        .N(2), .HOLD((g == 0) ? 1 : ((g == 1) ? 3 : 4)), .CNT_W(8)
      ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o_rdy[g]),
        .in_code(in_code), .en(en), .out_valid(o_vld[g]), .out_onehot(o_oh[g]),
        .busy(o_busy[g]), .count(o_cnt[g])
      );
    end
  endgenerate

  function automatic logic [14:0] exp_vec(int k);
    logic [3:0] oh;
    oh = (m_left[k] > 0) ? 4'(1 << m_word[k]) : 4'd0;
    return {m_left[k] > 0, oh, m_n[k] < 2, (m_left[k] > 0) || (m_n[k] > 0), 8'(m_words[k])};
  endfunction

  function automatic logic [14:0] obs_vec(int k);
    return {o_vld[k], o_oh[k], o_rdy[k], o_busy[k], o_cnt[k]};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_left[k] = 0; m_word[k] = 0; m_words[k] = 0;
    end
  endtask

  // One rising edge of behaviour: a word ends or starts, then a push joins the queue tail.
  task automatic model_edge();
    logic push;
    for (int k = 0; k < 3; k++) begin
      push = in_valid && (m_n[k] < 2);
      if (m_left[k] <= 1 && m_n[k] > 0 && en) begin
        m_word[k]    = int'(m_fifo[k][0]);
        m_fifo[k][0] = m_fifo[k][1];
        m_n[k]       = m_n[k] - 1;
        m_left[k]    = hold_v[k];
        m_words[k]   = m_words[k] + 1;
      end else if (m_left[k] > 0) begin
        m_left[k] = m_left[k] - 1;
      end
      if (push) begin
        m_fifo[k][m_n[k]] = in_code;
        m_n[k] = m_n[k] + 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    en = 1'b0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    checks++;
    if (o_vld !== 3'b000 || o_oh !== '0 || o_cnt !== '0 || o_busy !== 3'b000 || o_rdy !== 3'b111) begin
      failures++;
      $display("FAIL reset_hold vld=%b oh=%h cnt=%h busy=%b rdy=%b", o_vld, o_oh, o_cnt, o_busy, o_rdy);
    end
    rst = 1'b0;
    model_clear();
    repeat (4) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL idle k=%0d obs=%h exp=%h", k, obs_vec(k), exp_vec(k));
        end
      end
    end
    in_valid = 1'b1; in_code = 2'd1; en = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (o_vld[0] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_word obs=%b exp=1", o_vld[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o_vld !== 3'b000 || o_oh !== '0 || o_cnt !== '0 || o_busy !== 3'b000 || o_rdy !== 3'b111) begin
      failures++;
      $display("FAIL async_reset vld=%b oh=%h cnt=%h busy=%b rdy=%b", o_vld, o_oh, o_cnt, o_busy, o_rdy);
    end
    rst = 1'b0;
    en = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    apply_reset();
    in_valid = 1'b1; in_code = 2'd2; en = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (o_vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_no_bypass vld=%b exp=0", o_vld[0]);
    end
    tick();
    checks++;
    if (o_oh[0] !== 4'b0100 || o_vld[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_word oh=%b vld=%b exp=0100/1", o_oh[0], o_vld[0]);
    end
    tick();
    checks++;
    if (o_oh[0] !== 4'b0000 || o_cnt[0] !== 8'd1) begin
      failures++;
      $display("FAIL single_end oh=%b cnt=%0d exp=0000/1", o_oh[0], o_cnt[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        failures++;
        $display("FAIL single_model k=%0d obs=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] codes [4];
    int idx, vld_cycles, first, last;
    logic accept, saw_full;
    codes = '{2'd0, 2'd1, 2'd3, 2'd2};
    idx = 0; vld_cycles = 0; first = -1; last = -1; saw_full = 1'b0;
    apply_reset();
    en = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      in_valid = (idx < 4);
      if (idx < 4) in_code = codes[idx];
      accept = in_valid && o_rdy[1];
      tick();
      if (accept) idx++;
      checks++;
      if (obs_vec(1) !== exp_vec(1)) begin
        failures++;
        $display("FAIL b2b_model cyc=%0d obs=%h exp=%h", cyc, obs_vec(1), exp_vec(1));
      end
      if (o_vld[1]) begin
        vld_cycles++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (!o_rdy[1]) saw_full = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (vld_cycles != 12 || (last - first + 1) != 12) begin
      failures++;
      $display("FAIL b2b_span vld_cycles=%0d span=%0d exp=12/12", vld_cycles, last - first + 1);
    end
    checks++;
    if (saw_full !== 1'b1 || o_cnt[1] !== 8'd4) begin
      failures++;
      $display("FAIL b2b_full_count saw_full=%b cnt=%0d exp=1/4", saw_full, o_cnt[1]);
    end
  endtask

  task automatic test_flow();
    apply_reset();
    in_valid = 1'b1; in_code = 2'd1;
    tick();
    in_code = 2'd3;
    tick();
    in_valid = 1'b0;
    checks++;
    if (o_rdy[0] !== 1'b0 || o_vld[0] !== 1'b0) begin
      failures++;
      $display("FAIL flow_full rdy=%b vld=%b exp=0/0", o_rdy[0], o_vld[0]);
    end
    en = 1'b1;
    tick();
    checks++;
    if (o_oh[0] !== 4'b0010 || o_rdy[0] !== 1'b1) begin
      failures++;
      $display("FAIL flow_first oh=%b rdy=%b exp=0010/1", o_oh[0], o_rdy[0]);
    end
    tick();
    checks++;
    if (o_oh[0] !== 4'b1000) begin
      failures++;
      $display("FAIL flow_second oh=%b exp=1000", o_oh[0]);
    end
    tick();
    checks++;
    if (obs_vec(0) !== exp_vec(0) || o_oh[0] !== 4'b0000) begin
      failures++;
      $display("FAIL flow_idle obs=%h exp=%h", obs_vec(0), exp_vec(0));
    end
  endtask

  task automatic test_en_drop();
    apply_reset();
    en = 1'b1; in_valid = 1'b1; in_code = 2'd0;
    tick();
    in_code = 2'd3;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) in_valid = 1'b0;
      if (c == 1) en = 1'b0;
      checks++;
      if (o_oh[2] !== 4'b0001 || obs_vec(2) !== exp_vec(2)) begin
        failures++;
        $display("FAIL en_drop_word c=%0d oh=%b obs=%h exp=%h", c, o_oh[2], obs_vec(2), exp_vec(2));
      end
    end
    tick();
    checks++;
    if (o_oh[2] !== 4'b0000 || o_vld[2] !== 1'b0 || o_busy[2] !== 1'b1) begin
      failures++;
      $display("FAIL en_drop_idle oh=%b vld=%b busy=%b exp=0000/0/1", o_oh[2], o_vld[2], o_busy[2]);
    end
    repeat (2) tick();
    en = 1'b1;
    tick();
    checks++;
    if (o_oh[2] !== 4'b1000 || obs_vec(2) !== exp_vec(2)) begin
      failures++;
      $display("FAIL en_resume oh=%b obs=%h exp=%h", o_oh[2], obs_vec(2), exp_vec(2));
    end
  endtask

  task automatic test_reset_drive();
    apply_reset();
    en = 1'b1; in_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      in_code = 2'(c);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (o_vld[2] !== 1'b1 || o_rdy[2] !== 1'b0) begin
      failures++;
      $display("FAIL rd_pre vld=%b rdy=%b exp=1/0", o_vld[2], o_rdy[2]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (o_vld !== 3'b000 || o_oh !== '0 || o_rdy !== 3'b111 || o_cnt !== '0) begin
      failures++;
      $display("FAIL rd_async vld=%b oh=%h rdy=%b cnt=%h", o_vld, o_oh, o_rdy, o_cnt);
    end
    rst = 1'b0;
    model_clear();
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (o_vld !== 3'b000 || o_busy !== 3'b000 || obs_vec(2) !== exp_vec(2)) begin
        failures++;
        $display("FAIL rd_after c=%0d vld=%b busy=%b exp=000/000", c, o_vld, o_busy);
      end
    end
  endtask

  task automatic test_count_wrap();
    int guard;
    apply_reset();
    en = 1'b1; in_valid = 1'b1; guard = 0;
    while (m_words[0] < 256 && guard < 1000) begin
      in_code = 2'($urandom);
      tick();
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (m_words[0] != 256 || o_cnt[0] !== 8'd0) begin
      failures++;
      $display("FAIL count_wrap words=%0d cnt=%0d exp=256/0", m_words[0], o_cnt[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_vec(k) !== exp_vec(k)) begin
        failures++;
        $display("FAIL wrap_model k=%0d obs=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_code  = 2'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          failures++;
          $display("FAIL random c=%0d k=%0d obs=%h exp=%h", c, k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; en = 1'b0; in_code = 2'd0;
    model_clear();
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_flow();
    test_en_drop();
    test_reset_drive();
    test_count_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
